integrate_dump: RTL and testbench

//   Integrate-and-dump decimator: sums DECIM accepted WIDTH_IN-bit samples into a

---
 rtl/rounding_pkg.sv | 34 +++
 rtl/integrate_dump_sat_add.sv | 55 +++++
 rtl/integrate_dump.sv | 144 ++++++++++++++
 tb/tb_integrate_dump.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rounding_pkg.sv
// Shared saturation helpers for the integrate-and-dump / rounding datapath.
// Bounds are returned 64 bits wide; callers keep the low `width` bits.
package rounding_pkg;

  typedef struct packed {
    logic [63:0] hi;
    logic [63:0] lo;
  } sat_bounds_t;

  typedef enum logic [2:0] {
    ACT_HOLD  = 3'd0,
    ACT_CLEAR = 3'd1,
    ACT_IDLE  = 3'd2,
    ACT_ACCUM = 3'd3,
    ACT_DUMP  = 3'd4
  } id_action_e;

  function automatic sat_bounds_t sat_bounds(input int unsigned width, input bit is_signed);
    sat_bounds_t b;
    if (is_signed) begin
      b.hi = (64'd1 << (width - 32'd1)) - 64'd1;
      b.lo = ~b.hi;
    end else begin
      b.hi = (64'd1 << width) - 64'd1;
      b.lo = 64'd0;
    end
    return b;
  endfunction

  function automatic bit widths_ok(input int unsigned w_in, input int unsigned w_out);
    return (w_out >= w_in);
  endfunction

endpackage

// File: rtl/integrate_dump_sat_add.sv
// Combinational saturating adder: sum formed at W+1 bits, clamped back to W.
module sat_add
  import rounding_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter bit          IS_SIGNED = 1'b1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam sat_bounds_t BND = sat_bounds(W, IS_SIGNED);
  localparam logic [W-1:0] HI = BND.hi[W-1:0];
  localparam logic [W-1:0] LO = BND.lo[W-1:0];

  logic [W:0] raw_s;
  logic       ext_a_s;
  logic       ext_b_s;

  // Widened add and clamp toward the side the true result left the range.
  always_comb begin
    ext_a_s = 1'b0;
    ext_b_s = 1'b0;
    if (IS_SIGNED) begin
      ext_a_s = a[W-1];
      ext_b_s = b[W-1];
    end else begin
      ext_a_s = 1'b0;
      ext_b_s = 1'b0;
    end
    raw_s = {ext_a_s, a} + {ext_b_s, b};
    sum   = raw_s[W-1:0];
    ovf   = 1'b0;
    if (IS_SIGNED) begin
      ovf = raw_s[W] ^ raw_s[W-1];
      if (!ovf) begin
        sum = raw_s[W-1:0];
      end else if (raw_s[W]) begin
        sum = LO;
      end else begin
        sum = HI;
      end
    end else begin
      ovf = raw_s[W];
      if (ovf) begin
        sum = HI;
      end else begin
        sum = raw_s[W-1:0];
      end
    end
  end

endmodule

// File: rtl/integrate_dump.sv
// Integrate-and-dump decimator: saturating sum of DECIM accepted samples,
// emitted as a registered one-cycle pulse and then cleared.
module integrate_dump
  import rounding_pkg::*;
#(
  parameter int unsigned WIDTH_IN  = 16,
  parameter int unsigned WIDTH_OUT = 32,
  parameter int unsigned DECIM     = 16,
  parameter bit          IS_SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 clr,
  input  logic [WIDTH_IN-1:0]  din,
  input  logic                 din_valid,
  output logic [WIDTH_OUT-1:0] dout,
  output logic                 dout_valid,
  output logic                 dout_sat
);

  if (!widths_ok(WIDTH_IN, WIDTH_OUT)) begin : g_bad_width
    $error("integrate_dump: WIDTH_OUT must be >= WIDTH_IN");
  end
  if (DECIM < 1) begin : g_bad_decim
    $error("integrate_dump: DECIM must be >= 1");
  end

  localparam int unsigned   CNT_W = $clog2(DECIM) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

  logic [WIDTH_OUT-1:0] acc_r, acc_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic                 win_sat_r, win_sat_nxt_s;
  logic [WIDTH_OUT-1:0] dout_r, dout_nxt_s;
  logic                 dout_valid_r, dout_valid_nxt_s;
  logic                 dout_sat_r, dout_sat_nxt_s;

  logic                 sign_s;
  logic [WIDTH_OUT-1:0] din_ext_s;
  logic [WIDTH_OUT-1:0] sum_s;
  logic                 ovf_s;
  id_action_e           action_s;

  assign sign_s = IS_SIGNED ? din[WIDTH_IN-1] : 1'b0;

  // Sign- or zero-extend the incoming sample to accumulator width.
  always_comb begin
    din_ext_s = {WIDTH_OUT{sign_s}};
    din_ext_s[WIDTH_IN-1:0] = din;
  end

  sat_add #(
    .W         (WIDTH_OUT),
    .IS_SIGNED (IS_SIGNED)
  ) u_sat_add (
    .a   (acc_r),
    .b   (din_ext_s),
    .sum (sum_s),
    .ovf (ovf_s)
  );

  // Decode what this cycle does; clr wins even while ena is low.
  always_comb begin
    action_s = ACT_HOLD;
    if (clr) begin
      action_s = ACT_CLEAR;
    end else if (ena) begin
      if (din_valid) begin
        if (cnt_r == LAST) begin
          action_s = ACT_DUMP;
        end else begin
          action_s = ACT_ACCUM;
        end
      end else begin
        action_s = ACT_IDLE;
      end
    end else begin
      action_s = ACT_HOLD;
    end
  end

  // Next-state values for the window and the output registers.
  always_comb begin
    acc_nxt_s        = acc_r;
    cnt_nxt_s        = cnt_r;
    win_sat_nxt_s    = win_sat_r;
    dout_nxt_s       = dout_r;
    dout_valid_nxt_s = dout_valid_r;
    dout_sat_nxt_s   = dout_sat_r;
    case (action_s)
      ACT_CLEAR: begin
        acc_nxt_s        = '0;
        cnt_nxt_s        = '0;
        win_sat_nxt_s    = 1'b0;
        dout_valid_nxt_s = 1'b0;
      end
      ACT_IDLE: begin
        dout_valid_nxt_s = 1'b0;
      end
      ACT_ACCUM: begin
        acc_nxt_s        = sum_s;
        cnt_nxt_s        = cnt_r + CNT_W'(1);
        win_sat_nxt_s    = win_sat_r | ovf_s;
        dout_valid_nxt_s = 1'b0;
      end
      ACT_DUMP: begin
        dout_nxt_s       = sum_s;
        dout_valid_nxt_s = 1'b1;
        dout_sat_nxt_s   = win_sat_r | ovf_s;
        acc_nxt_s        = '0;
        cnt_nxt_s        = '0;
        win_sat_nxt_s    = 1'b0;
      end
      default: begin
        acc_nxt_s = acc_r;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r        <= '0;
      cnt_r        <= '0;
      win_sat_r    <= 1'b0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      dout_sat_r   <= 1'b0;
    end else begin
      acc_r        <= acc_nxt_s;
      cnt_r        <= cnt_nxt_s;
      win_sat_r    <= win_sat_nxt_s;
      dout_r       <= dout_nxt_s;
      dout_valid_r <= dout_valid_nxt_s;
      dout_sat_r   <= dout_sat_nxt_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_sat   = dout_sat_r;

endmodule

// File: tb/tb_integrate_dump.sv
// Bench for integrate_dump: four configurations share one stimulus stream and
// are checked every cycle against an integer-arithmetic reference model.
module tb_integrate_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        clr;
  logic        din_valid;
  logic [15:0] din;

  logic [31:0] o0_dout;
  logic [17:0] o1_dout;
  logic [17:0] o2_dout;
  logic [15:0] o3_dout;
  logic        o0_dv, o1_dv, o2_dv, o3_dv;
  logic        o0_sat, o1_sat, o2_sat, o3_sat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  integrate_dump #(.WIDTH_IN(16), .WIDTH_OUT(32), .DECIM(4), .IS_SIGNED(1'b1)) u_s4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .din(din), .din_valid(din_valid),
    .dout(o0_dout), .dout_valid(o0_dv), .dout_sat(o0_sat));
  integrate_dump #(.WIDTH_IN(16), .WIDTH_OUT(18), .DECIM(8), .IS_SIGNED(1'b1)) u_s18 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .din(din), .din_valid(din_valid),
    .dout(o1_dout), .dout_valid(o1_dv), .dout_sat(o1_sat));
  integrate_dump #(.WIDTH_IN(16), .WIDTH_OUT(18), .DECIM(8), .IS_SIGNED(1'b0)) u_u18 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .din(din), .din_valid(din_valid),
    .dout(o2_dout), .dout_valid(o2_dv), .dout_sat(o2_sat));
  integrate_dump #(.WIDTH_IN(16), .WIDTH_OUT(16), .DECIM(1), .IS_SIGNED(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .din(din), .din_valid(din_valid),
    .dout(o3_dout), .dout_valid(o3_dv), .dout_sat(o3_sat));

  logic [63:0] obs_dout [4];
  logic        obs_dv   [4];
  logic        obs_sat  [4];
  assign obs_dout[0] = 64'(o0_dout);
  assign obs_dout[1] = 64'(o1_dout);
  assign obs_dout[2] = 64'(o2_dout);
  assign obs_dout[3] = 64'(o3_dout);
  assign obs_dv[0] = o0_dv;  assign obs_sat[0] = o0_sat;
  assign obs_dv[1] = o1_dv;  assign obs_sat[1] = o1_sat;
  assign obs_dv[2] = o2_dv;  assign obs_sat[2] = o2_sat;
  assign obs_dv[3] = o3_dv;  assign obs_sat[3] = o3_sat;

  localparam int P_WO  [4] = '{32, 18, 18, 16};
  localparam int P_DEC [4] = '{4, 8, 8, 1};
  localparam bit P_SG  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  // Reference state: true integer values, not bit patterns.
  longint m_acc  [4];
  longint m_dout [4];
  int     m_cnt  [4];
  bit     m_ws   [4];
  bit     m_dv   [4];
  bit     m_sat  [4];

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = 0; m_dout[k] = 0; m_cnt[k] = 0;
      m_ws[k] = 1'b0; m_dv[k] = 1'b0; m_sat[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    longint x, s, hi, lo;
    bit     ovf;
    for (int k = 0; k < 4; k++) begin
      if (clr) begin
        m_acc[k] = 0; m_cnt[k] = 0; m_ws[k] = 1'b0; m_dv[k] = 1'b0;
      end else if (ena) begin
        m_dv[k] = 1'b0;
        if (din_valid) begin
          x  = P_SG[k] ? longint'($signed(din)) : longint'({48'd0, din});
          hi = P_SG[k] ? (64'sd1 <<< (P_WO[k] - 1)) - 1 : (64'sd1 <<< P_WO[k]) - 1;
          lo = P_SG[k] ? -(64'sd1 <<< (P_WO[k] - 1)) : 0;
          s  = m_acc[k] + x;
          ovf = (s > hi) || (s < lo);
          if (s > hi) s = hi;
          if (s < lo) s = lo;
          if (m_cnt[k] == P_DEC[k] - 1) begin
            m_dout[k] = s; m_dv[k] = 1'b1; m_sat[k] = m_ws[k] | ovf;
            m_acc[k] = 0; m_cnt[k] = 0; m_ws[k] = 1'b0;
          end else begin
            m_acc[k] = s; m_cnt[k] = m_cnt[k] + 1; m_ws[k] = m_ws[k] | ovf;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [63:0] mask;
    for (int k = 0; k < 4; k++) begin
      mask = (64'd1 << P_WO[k]) - 64'd1;
      check($sformatf("%s.i%0d.dout", where, k), obs_dout[k], 64'(m_dout[k]) & mask);
      check($sformatf("%s.i%0d.dv", where, k), 64'(obs_dv[k]), 64'(m_dv[k]));
      check($sformatf("%s.i%0d.sat", where, k), 64'(obs_sat[k]), 64'(m_sat[k]));
    end
  endtask

  // Drive one cycle's inputs just after a falling edge, check at the next one.
  task automatic step(input logic e, input logic c, input logic v, input logic [15:0] d);
    ena = e; clr = c; din_valid = v; din = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all("step");
  endtask

  initial begin
    logic [15:0] pat_v;
    rst_n = 1'b0; ena = 1'b0; clr = 1'b0; din_valid = 1'b0; din = 16'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Four back-to-back 1000s, then freeze and release of dout_valid.
    step(1'b1, 1'b1, 1'b0, 16'd0);
    repeat (4) step(1'b1, 1'b0, 1'b1, 16'd1000);
    check("t1.dout", obs_dout[0], 64'd4000);
    check("t1.dv", 64'(obs_dv[0]), 64'd1);
    check("t1.sat", 64'(obs_sat[0]), 64'd0);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check("t1.dv_frozen", 64'(obs_dv[0]), 64'd1);
    step(1'b1, 1'b0, 1'b0, 16'd0);
    check("t1.dv_drop", 64'(obs_dv[0]), 64'd0);

    // Saturation at 18 bits, both signs and unsigned.
    step(1'b1, 1'b1, 1'b0, 16'd0);
    repeat (8) step(1'b1, 1'b0, 1'b1, 16'd32767);
    check("t2.pos.dout", obs_dout[1], 64'h1FFFF);
    check("t2.pos.sat", 64'(obs_sat[1]), 64'd1);
    step(1'b1, 1'b1, 1'b0, 16'd0);
    repeat (8) step(1'b1, 1'b0, 1'b1, 16'h8000);
    check("t2.neg.dout", obs_dout[1], 64'h20000);
    check("t2.neg.sat", 64'(obs_sat[1]), 64'd1);
    step(1'b1, 1'b1, 1'b0, 16'd0);
    repeat (8) step(1'b1, 1'b0, 1'b1, 16'hFFFF);
    check("t2.uns.dout", obs_dout[2], 64'h3FFFF);
    check("t2.uns.sat", 64'(obs_sat[2]), 64'd1);
    check("t2.d1.dout", obs_dout[3], 64'hFFFF);
    check("t2.d1.sat", 64'(obs_sat[3]), 64'd0);

    // Valid gaps do not advance the window.
    step(1'b1, 1'b1, 1'b0, 16'd0);
    pat_v = 16'b1011001;
    for (int i = 6; i >= 0; i--) step(1'b1, 1'b0, pat_v[i], 16'd3);
    check("t3.dout", obs_dout[0], 64'd12);
    check("t3.dv", 64'(obs_dv[0]), 64'd1);

    // Restart mid-window, and an ena=0 pause mid-window.
    step(1'b1, 1'b1, 1'b0, 16'd0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd5);
    step(1'b1, 1'b1, 1'b1, 16'd5);
    check("t4.clr_dv", 64'(obs_dv[0]), 64'd0);
    repeat (4) step(1'b1, 1'b0, 1'b1, 16'd7);
    check("t4.clr.dout", obs_dout[0], 64'd28);
    check("t4.clr.dv", 64'(obs_dv[0]), 64'd1);
    step(1'b1, 1'b1, 1'b0, 16'd0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd7);
    repeat (3) step(1'b0, 1'b0, 1'b1, 16'd7);
    check("t4.pause.dv", 64'(obs_dv[0]), 64'd0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd7);
    check("t4.pause.dout", obs_dout[0], 64'd28);
    check("t4.pause.dv1", 64'(obs_dv[0]), 64'd1);

    // Asynchronous reset between edges, then a fresh window of 2s.
    repeat (2) step(1'b1, 1'b0, 1'b1, 16'd2);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("t5.rst.dout", obs_dout[0], 64'd0);
    check("t5.rst.dv", 64'(obs_dv[0]), 64'd0);
    check_all("t5.rst");
    #1 rst_n = 1'b1;
    repeat (4) step(1'b1, 1'b0, 1'b1, 16'd2);
    check("t5.dout", obs_dout[0], 64'd8);
    check("t5.dv", 64'(obs_dv[0]), 64'd1);

    // Randomised traffic with extreme values mixed in.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0: d = 16'h7FFF;
        1: d = 16'h8000;
        default: d = 16'($urandom);
      endcase
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) < 7), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
